// File: rtl/hazard_tracker.sv
// Load-use hazard tracker: EX/MEM/WB destination tags, stall and
// fetch/decode hold generation, saturating stall counter.
module hazard_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ID_rs,
  input  logic [2:0] ID_rt,
  input  logic [2:0] ID_rd,
  input  logic       ID_RegWrite,
  input  logic       ID_MemRead,
  input  logic       ID_use_rs,
  input  logic       ID_use_rt,
  input  logic       flush_id,
  input  logic       freeze,
  output logic [2:0] EX_rs,
  output logic [2:0] EX_rt,
  output logic [2:0] MEM_rd,
  output logic [2:0] WB_rd,
  output logic       MEM_RegWrite,
  output logic       WB_RegWrite,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic [7:0] stall_count
);

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic       rw;
    logic       mr;
  } ex_tag_t;

  typedef struct packed {
    logic [2:0] rd;
    logic       rw;
    logic       mr;
  } wb_tag_t;

  ex_tag_t    ex_q, ex_d;
  wb_tag_t    mem_q, mem_d;
  wb_tag_t    wb_q, wb_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hit_rs, hit_rt;
  logic       load_use;

  always_comb begin
    hit_rs   = ID_use_rs && (ex_q.rd == ID_rs);
    hit_rt   = ID_use_rt && (ex_q.rd == ID_rt);
    load_use = ex_q.mr && ex_q.rw && (ex_q.rd != 3'd0)
               && (hit_rs || hit_rt);
    // a flush replaces the stalled instruction, so fetch moves on
    PC_Write   = !freeze && (flush_id || !load_use);
    IFID_Write = PC_Write;
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    priority case (1'b1)
      freeze: begin
      end
      flush_id || load_use: begin
        ex_d  = '0;
        mem_d = '{rd: ex_q.rd, rw: ex_q.rw, mr: ex_q.mr};
        wb_d  = mem_q;
        if (!flush_id && cnt_q != 8'hff)
          cnt_d = cnt_q + 8'd1;
      end
      default: begin
        ex_d  = '{rs: ID_rs, rt: ID_rt, rd: ID_rd,
                  rw: ID_RegWrite, mr: ID_MemRead};
        mem_d = '{rd: ex_q.rd, rw: ex_q.rw, mr: ex_q.mr};
        wb_d  = mem_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign EX_rs        = ex_q.rs;
  assign EX_rt        = ex_q.rt;
  assign MEM_rd       = mem_q.rd;
  assign WB_rd        = wb_q.rd;
  assign MEM_RegWrite = mem_q.rw;
  assign WB_RegWrite  = wb_q.rw;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: stimulus pushes expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ID_rs, ID_rt, ID_rd;
  logic       ID_RegWrite, ID_MemRead;
  logic       ID_use_rs, ID_use_rt;
  logic       flush_id, freeze;
  logic [2:0] EX_rs, EX_rt, MEM_rd, WB_rd;
  logic       MEM_RegWrite, WB_RegWrite;
  logic       PC_Write, IFID_Write;
  logic [7:0] stall_count;

  hazard_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .flush_id(flush_id), .freeze(freeze),
    .EX_rs(EX_rs), .EX_rt(EX_rt),
    .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ex_rs;
    logic [2:0] ex_rt;
    logic [2:0] mem_rd;
    logic [2:0] wb_rd;
    logic       mem_rw;
    logic       wb_rw;
    logic       pcw;
    logic       ifw;
    logic [7:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // reference pipeline state, as it stands after the last edge
  logic [2:0] m_ex_rs, m_ex_rt, m_ex_rd, m_mem_rd, m_wb_rd;
  logic       m_ex_rw, m_ex_mr, m_mem_rw, m_wb_rw;
  logic [7:0] m_cnt;

  function automatic exp_t observed();
    exp_t g;
    g.ex_rs  = EX_rs;
    g.ex_rt  = EX_rt;
    g.mem_rd = MEM_rd;
    g.wb_rd  = WB_rd;
    g.mem_rw = MEM_RegWrite;
    g.wb_rw  = WB_RegWrite;
    g.pcw    = PC_Write;
    g.ifw    = IFID_Write;
    g.cnt    = stall_count;
    return g;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = observed();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got {ex_rs,ex_rt,mem_rd,wb_rd,mrw,wrw,pcw,ifw,cnt}=%h want %h",
                 nm, g, e);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic model_zero();
    m_ex_rs = 0; m_ex_rt = 0; m_ex_rd = 0;
    m_ex_rw = 0; m_ex_mr = 0;
    m_mem_rd = 0; m_mem_rw = 0;
    m_wb_rd = 0; m_wb_rw = 0;
    m_cnt = 0;
  endtask

  function automatic logic model_stall();
    logic dep;
    dep = (ID_use_rs && ID_rs == m_ex_rd)
       || (ID_use_rt && ID_rt == m_ex_rd);
    return m_ex_mr && m_ex_rw && m_ex_rd != 0 && dep;
  endfunction

  // advance the reference across the next rising edge
  task automatic apply_edge();
    logic st;
    st = model_stall();
    if (!freeze) begin
      m_wb_rd  = m_mem_rd;
      m_wb_rw  = m_mem_rw;
      m_mem_rd = m_ex_rd;
      m_mem_rw = m_ex_rw;
      if (flush_id || st) begin
        m_ex_rs = 0; m_ex_rt = 0; m_ex_rd = 0;
        m_ex_rw = 0; m_ex_mr = 0;
        if (!flush_id && m_cnt != 8'd255) m_cnt = m_cnt + 1;
      end else begin
        m_ex_rs = ID_rs; m_ex_rt = ID_rt; m_ex_rd = ID_rd;
        m_ex_rw = ID_RegWrite; m_ex_mr = ID_MemRead;
      end
    end
  endtask

  task automatic step(input logic [2:0] rs, rt, rd,
                      input logic rw, mr, urs, urt, fl, fz,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    ID_rs = rs; ID_rt = rt; ID_rd = rd;
    ID_RegWrite = rw; ID_MemRead = mr;
    ID_use_rs = urs; ID_use_rt = urt;
    flush_id = fl; freeze = fz;
    e.ex_rs  = m_ex_rs;
    e.ex_rt  = m_ex_rt;
    e.mem_rd = m_mem_rd;
    e.wb_rd  = m_wb_rd;
    e.mem_rw = m_mem_rw;
    e.wb_rw  = m_wb_rw;
    e.pcw    = !fz && (fl || !model_stall());
    e.ifw    = e.pcw;
    e.cnt    = m_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    apply_edge();
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ID_rs = 0; ID_rt = 0; ID_rd = 0;
    ID_RegWrite = 0; ID_MemRead = 0;
    ID_use_rs = 0; ID_use_rt = 0;
    flush_id = 0; freeze = 0;
    model_zero();
    #1;
    chk("rst_ex_rs", EX_rs, 0);
    chk("rst_wb_rd", WB_rd, 0);
    chk("rst_cnt", stall_count, 0);
    chk("rst_pcw", PC_Write, 1);
    #1 rst_n = 1'b1;

    // load r3 then add reading r3: one stall, then add enters EX
    step(1, 0, 3, 1, 1, 0, 0, 0, 0, "lw_r3");
    step(3, 4, 5, 1, 0, 1, 1, 0, 0, "add_stall");
    at_neg();
    chk("lu_pcw", PC_Write, 0);
    chk("lu_ifw", IFID_Write, 0);
    step(3, 4, 5, 1, 0, 1, 1, 0, 0, "add_retry");
    at_neg();
    chk("bubble_ex_rs", EX_rs, 0);
    chk("load_in_mem", MEM_rd, 3);
    chk("retry_pcw", PC_Write, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "nop1");
    at_neg();
    chk("add_ex_rs", EX_rs, 3);
    chk("load_in_wb", WB_rd, 3);
    chk("cnt_one", stall_count, 1);

    // loads that must never stall
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, "lw_r0");
    step(0, 0, 6, 1, 0, 1, 1, 0, 0, "use_r0");
    step(1, 0, 2, 0, 1, 0, 0, 0, 0, "lw_norw");
    step(2, 2, 6, 1, 0, 1, 1, 0, 0, "use_norw");
    step(2, 0, 4, 1, 1, 0, 0, 0, 0, "lw_r4");
    step(1, 4, 6, 1, 0, 1, 0, 0, 0, "rt_unused");
    at_neg();
    chk("no_stall_cnt", stall_count, 1);

    // flush on the dependent cycle overrides the stall
    step(1, 0, 5, 1, 1, 0, 0, 0, 0, "lw_r5");
    step(5, 0, 7, 1, 0, 1, 0, 1, 0, "flush_dep");
    at_neg();
    chk("flush_pcw", PC_Write, 1);
    step(1, 2, 3, 1, 0, 1, 1, 0, 0, "after_flush");
    at_neg();
    chk("flush_bubble", EX_rs, 0);
    chk("flush_cnt", stall_count, 1);

    // freeze three cycles with a load-use pending, then resume
    step(1, 0, 6, 1, 1, 0, 0, 0, 0, "lw_r6");
    for (int i = 0; i < 3; i++)
      step(2, 6, 7, 1, 0, 0, 1, 0, 1, "frozen");
    step(2, 6, 7, 1, 0, 0, 1, 0, 0, "thaw_stall");
    step(2, 6, 7, 1, 0, 0, 1, 0, 0, "thaw_go");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "nop2");
    at_neg();
    chk("thaw_ex_rt", EX_rt, 6);
    chk("thaw_cnt", stall_count, 2);

    // saturate the stall counter
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 1, 1, 1, 0, 0, 0, 0, "sat_lw");
      step(1, 0, 2, 1, 0, 1, 0, 0, 0, "sat_stall");
      step(1, 0, 2, 1, 0, 1, 0, 0, 0, "sat_go");
    end
    at_neg();
    chk("sat_cnt", stall_count, 255);

    // reset pulse between edges while a stall is pending
    step(0, 0, 2, 1, 1, 0, 0, 0, 0, "lw_r2");
    step(2, 0, 3, 1, 0, 1, 0, 0, 0, "pre_rst_stall");
    at_neg();
    rst_n = 1'b0;
    #1;
    chk("arst_mem_rd", MEM_rd, 0);
    chk("arst_mem_rw", MEM_RegWrite, 0);
    chk("arst_cnt", stall_count, 0);
    chk("arst_pcw", PC_Write, 1);
    #1 rst_n = 1'b1;
    model_zero();
    apply_edge();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst");
    at_neg();
    chk("post_rst_ex_rs", EX_rs, 2);
    chk("post_rst_cnt", stall_count, 0);

    at_neg();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
